// File: rtl/aether_pifo_pkg.sv
// Shared definitions for the Aether PIFO command path.
//   aether_entry_t        : one tree entry, {metadata, priority tag}
//   AETHER_OP_PUSH / _POP : node command opcodes
//   aether_sched_state_t  : command scheduler FSM states
package aether_pifo_pkg;

    localparam int AETHER_PTW = 16;
    localparam int AETHER_MTW = 32;

    typedef logic [AETHER_MTW+AETHER_PTW-1:0] aether_entry_t;

    localparam logic AETHER_OP_PUSH = 1'b0;
    localparam logic AETHER_OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOL     = 2'd1,
        ST_POP_WAIT = 2'd2
    } aether_sched_state_t;

endpackage

// File: rtl/aether_rr_arb.sv
// NREQ-way round-robin arbiter (purely combinational).
//   i_req : request vector
//   i_ptr : index of the highest-priority requester this cycle
//   o_gnt : one-hot grant to the first requester at or after i_ptr,
//           wrapping around; all zero when nothing is requested
// NREQ must be a power of two so the index arithmetic wraps naturally.
module aether_rr_arb
    import aether_pifo_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = i_ptr + PW'(i);
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aether_pifo_cmd_sched.sv
// Command scheduler in front of the root node of an Aether PIFO tree.
// Shares the node's single command port between NREQ push requesters and
// one pop consumer, keeps node commands at least ISSUE_GAP cycles apart,
// tracks tree occupancy and returns popped entries with a valid strobe.
//
// Ports
//   i_clk, i_arst_n        : clock, asynchronous active-low reset
//   i_push_valid/_data     : per-requester push request, slice k = requester k
//   o_push_ready           : one-hot push grant (transfer on valid & ready)
//   i_pop_valid/o_pop_ready: pop request / pop accepted this cycle
//   o_rsp_valid/_data      : one-cycle strobe with the popped entry (data held)
//   o_n_valid/_op/_data    : registered node command (op 0 = push, 1 = pop)
//   i_n_pop_data           : node head entry, sampled POP_LAT cycles after a pop
//   o_occupancy/o_full/o_empty : tree entry count and its limits
//
// Build option AETHER_SCHED_STATS_EN adds wrapping 32-bit counters
// o_stat_push_cnt, o_stat_pop_cnt and o_stat_block_cnt.
module aether_pifo_cmd_sched
    import aether_pifo_pkg::*;
#(
    parameter int PTW        = 16,
    parameter int MTW        = 32,
    parameter int NREQ       = 4,
    parameter int CAPACITY   = 64,
    parameter int ISSUE_GAP  = 2,
    parameter int POP_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                           i_clk,
    input  logic                           i_arst_n,
    input  logic [NREQ-1:0]                i_push_valid,
    input  logic [NREQ*(MTW+PTW)-1:0]      i_push_data,
    output logic [NREQ-1:0]                o_push_ready,
    input  logic                           i_pop_valid,
    output logic                           o_pop_ready,
    output logic                           o_rsp_valid,
    output logic [MTW+PTW-1:0]             o_rsp_data,
    output logic                           o_n_valid,
    output logic                           o_n_op,
    output logic [MTW+PTW-1:0]             o_n_data,
    input  logic [MTW+PTW-1:0]             i_n_pop_data,
    output logic [$clog2(CAPACITY+1)-1:0]  o_occupancy,
    output logic                           o_full,
    output logic                           o_empty
`ifdef AETHER_SCHED_STATS_EN
    ,
    output logic [31:0]                    o_stat_push_cnt,
    output logic [31:0]                    o_stat_pop_cnt,
    output logic [31:0]                    o_stat_block_cnt
`endif
);

    localparam int EW = MTW + PTW;
    localparam int OW = $clog2(CAPACITY + 1);
    localparam int PW = $clog2(NREQ);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int CW = $clog2(ISSUE_GAP + 1);
    localparam int LW = $clog2(POP_LAT + 1);
    // A pop occupies the grant cycle, POP_LAT cycles to capture and one
    // cycle to present the response before the FSM may return to IDLE.
    // Whatever is left of ISSUE_GAP after that is spent in COOL.
    localparam int POST_GAP = ISSUE_GAP - (POP_LAT + 2);

    aether_sched_state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [LW-1:0] wait_q, wait_d;
    logic          n_valid_q, n_valid_d;
    logic          n_op_q, n_op_d;
    logic [EW-1:0] n_data_q, n_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [EW-1:0] rsp_data_q, rsp_data_d;
    logic [EW-1:0] cap_q, cap_d;

    logic [NREQ-1:0] arb_gnt;
    logic [NREQ-1:0] push_ready;
    logic            pop_ready;
    logic [PW-1:0]   gnt_idx;
    logic [EW-1:0]   gnt_data;
    logic            full, empty, any_push, pop_ok, push_ok, do_pop;

    aether_rr_arb #(.NREQ(NREQ)) u_arb (
        .i_req (i_push_valid),
        .i_ptr (ptr_q),
        .o_gnt (arb_gnt)
    );

    always_comb begin
        full     = (occ_q == OW'(CAPACITY));
        empty    = (occ_q == '0);
        any_push = |i_push_valid;
        pop_ok   = i_pop_valid && !empty;
        push_ok  = any_push && !full;

        gnt_idx  = '0;
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                gnt_idx  = PW'(k);
                gnt_data = i_push_data[k*EW +: EW];
            end
        end

        state_d     = state_q;
        ptr_d       = ptr_q;
        starve_d    = starve_q;
        occ_d       = occ_q;
        cool_d      = cool_q;
        wait_d      = wait_q;
        n_valid_d   = 1'b0;
        n_op_d      = AETHER_OP_PUSH;
        n_data_d    = '0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        cap_d       = cap_q;
        push_ready  = '0;
        pop_ready   = 1'b0;
        do_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Pop has priority until pushes have been passed over
                // STARVE_LIM times in a row.
                do_pop = pop_ok && !(push_ok && (starve_q == SW'(STARVE_LIM)));
                if (do_pop) begin
                    pop_ready = 1'b1;
                    n_valid_d = 1'b1;
                    n_op_d    = AETHER_OP_POP;
                    occ_d     = occ_q - OW'(1);
                    if (!push_ok)
                        starve_d = '0;
                    else if (starve_q != SW'(STARVE_LIM))
                        starve_d = starve_q + SW'(1);
                    wait_d  = LW'(POP_LAT);
                    state_d = ST_POP_WAIT;
                end else if (push_ok) begin
                    push_ready = arb_gnt;
                    n_valid_d  = 1'b1;
                    n_op_d     = AETHER_OP_PUSH;
                    n_data_d   = gnt_data;
                    occ_d      = occ_q + OW'(1);
                    ptr_d      = gnt_idx + PW'(1);
                    starve_d   = '0;
                    if (ISSUE_GAP > 1) begin
                        cool_d  = CW'(ISSUE_GAP - 2);
                        state_d = ST_COOL;
                    end
                end
            end
            ST_COOL: begin
                if (cool_q == '0)
                    state_d = ST_IDLE;
                else
                    cool_d = cool_q - CW'(1);
            end
            ST_POP_WAIT: begin
                // wait_q == 1: node head is valid now; wait_q == 0: present it.
                if (wait_q == LW'(1))
                    cap_d = i_n_pop_data;
                if (wait_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cap_q;
                    if (POST_GAP > 0) begin
                        cool_d  = CW'(POST_GAP - 1);
                        state_d = ST_COOL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_d = wait_q - LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- grant stage -> registered node command / response ----
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            starve_q    <= '0;
            occ_q       <= '0;
            cool_q      <= '0;
            wait_q      <= '0;
            n_valid_q   <= 1'b0;
            n_op_q      <= 1'b0;
            n_data_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            starve_q    <= starve_d;
            occ_q       <= occ_d;
            cool_q      <= cool_d;
            wait_q      <= wait_d;
            n_valid_q   <= n_valid_d;
            n_op_q      <= n_op_d;
            n_data_q    <= n_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Capture register is only read after being loaded, so it needs no reset.
    always_ff @(posedge i_clk) begin
        cap_q <= cap_d;
    end

    assign o_push_ready = push_ready;
    assign o_pop_ready  = pop_ready;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_n_valid    = n_valid_q;
    assign o_n_op       = n_op_q;
    assign o_n_data     = n_data_q;
    assign o_occupancy  = occ_q;
    assign o_full       = full;
    assign o_empty      = empty;

`ifdef AETHER_SCHED_STATS_EN
    logic [31:0] stat_push_q, stat_push_d;
    logic [31:0] stat_pop_q, stat_pop_d;
    logic [31:0] stat_block_q, stat_block_d;
    logic        blocked;

    always_comb begin
        blocked      = (state_q == ST_IDLE) &&
                       ((any_push && full) || (i_pop_valid && empty));
        stat_push_d  = stat_push_q  + ((|push_ready) ? 32'd1 : 32'd0);
        stat_pop_d   = stat_pop_q   + (pop_ready     ? 32'd1 : 32'd0);
        stat_block_d = stat_block_q + (blocked       ? 32'd1 : 32'd0);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stat_push_q  <= '0;
            stat_pop_q   <= '0;
            stat_block_q <= '0;
        end else begin
            stat_push_q  <= stat_push_d;
            stat_pop_q   <= stat_pop_d;
            stat_block_q <= stat_block_d;
        end
    end

    assign o_stat_push_cnt  = stat_push_q;
    assign o_stat_pop_cnt   = stat_pop_q;
    assign o_stat_block_cnt = stat_block_q;
`endif

endmodule
